// File: rtl/input_conditioner.sv
// Synchronises and debounces switches and pushbuttons, then derives button edge pulses and sticky
// active-low irqs. Define INPUT_COND_FALL_IRQ_EN to also raise an irq on button release.
module input_conditioner #(
  parameter int unsigned N_SW            = 8,
  parameter int unsigned N_PB            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16000,
  parameter bit          RESET_LEVEL     = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_in,
  input  logic [N_PB-1:0] pb_in,
  input  logic [N_PB-1:0] irq_ack,
  output logic [N_SW-1:0] sw_out,
  output logic [N_PB-1:0] pb_level,
  output logic [N_PB-1:0] pb_rise,
  output logic [N_PB-1:0] pb_fall,
  output logic [N_PB-1:0] irq_n,
  output logic            reset_req
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned N_CH  = N_SW + N_PB;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Buttons occupy the top channels, switches the bottom ones.
  logic [N_CH-1:0]            raw;
  logic [N_CH-1:0]            s1_q, s2_q;
  logic [N_CH-1:0]            stable_q, stable_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [N_PB-1:0] pb_stable_q, pb_stable_d;
  logic [N_PB-1:0] rise_q, fall_q;
  logic [N_PB-1:0] irq_n_q;
  logic [N_PB-1:0] pend_set, pend_d;

  assign raw = {pb_in, sw_in};

  // Counter restarts whenever s2 matches the accepted level, which rejects short glitches.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] >= CNT_MAX) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign pb_stable_q = stable_q[N_CH-1:N_SW];
  assign pb_stable_d = stable_d[N_CH-1:N_SW];

`ifdef INPUT_COND_FALL_IRQ_EN
  assign pend_set = rise_q | fall_q;
`else
  assign pend_set = rise_q;
`endif

  // Set has priority over a simultaneous ack.
  assign pend_d = pend_set | (~irq_n_q & ~irq_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= {N_CH{RESET_LEVEL}};
      s2_q     <= {N_CH{RESET_LEVEL}};
      stable_q <= {N_CH{RESET_LEVEL}};
      cnt_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      irq_n_q  <= '1;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= pb_stable_d & ~pb_stable_q;
      fall_q   <= ~pb_stable_d & pb_stable_q;
      irq_n_q  <= ~pend_d;
    end
  end

  assign sw_out    = stable_q[N_SW-1:0];
  assign pb_level  = pb_stable_q;
  assign pb_rise   = rise_q;
  assign pb_fall   = fall_q;
  assign irq_n     = irq_n_q;
  assign reset_req = pb_stable_q[0];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4: a vector table for steady-state
// levels and irq handshakes, plus hand sequences for reset, edge pulses and set/ack collisions.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw_in;
  logic [3:0] pb_in;
  logic [3:0] irq_ack;
  logic [7:0] sw_out;
  logic [3:0] pb_level, pb_rise, pb_fall, irq_n;
  logic       reset_req;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef INPUT_COND_FALL_IRQ_EN
  localparam bit FALL_IRQ = 1'b1;
`else
  localparam bit FALL_IRQ = 1'b0;
`endif

  input_conditioner #(
    .N_SW(8),
    .N_PB(4),
    .DEBOUNCE_CYCLES(4),
    .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_in(sw_in),
    .pb_in(pb_in),
    .irq_ack(irq_ack),
    .sw_out(sw_out),
    .pb_level(pb_level),
    .pb_rise(pb_rise),
    .pb_fall(pb_fall),
    .irq_n(irq_n),
    .reset_req(reset_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sw;
    logic [3:0] pb;
    logic [3:0] ack;
    int         cycles;
    logic [7:0] exp_sw;
    logic [3:0] exp_pb;
    logic [3:0] exp_irq_n;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Glitch rejection and exact latency on sw[3], multi-bit switch change, irq handshake on pb[1].
    vecs[0]  = '{8'h08, 4'h0, 4'h0, 3, 8'h00, 4'h0, 4'hF};
    vecs[1]  = '{8'h00, 4'h0, 4'h0, 6, 8'h00, 4'h0, 4'hF};
    vecs[2]  = '{8'h08, 4'h0, 4'h0, 4, 8'h00, 4'h0, 4'hF};
    vecs[3]  = '{8'h08, 4'h0, 4'h0, 1, 8'h00, 4'h0, 4'hF};
    vecs[4]  = '{8'h08, 4'h0, 4'h0, 1, 8'h08, 4'h0, 4'hF};
    vecs[5]  = '{8'hA5, 4'h0, 4'h0, 5, 8'h08, 4'h0, 4'hF};
    vecs[6]  = '{8'hA5, 4'h0, 4'h0, 1, 8'hA5, 4'h0, 4'hF};
    vecs[7]  = '{8'hA5, 4'h2, 4'h0, 6, 8'hA5, 4'h2, 4'hF};
    vecs[8]  = '{8'hA5, 4'h2, 4'h0, 1, 8'hA5, 4'h2, 4'hD};
    vecs[9]  = '{8'hA5, 4'h2, 4'h4, 1, 8'hA5, 4'h2, 4'hD};
    vecs[10] = '{8'hA5, 4'h2, 4'h0, 3, 8'hA5, 4'h2, 4'hD};
    vecs[11] = '{8'hA5, 4'h2, 4'h2, 1, 8'hA5, 4'h2, 4'hF};
    vecs[12] = '{8'hA5, 4'h2, 4'h0, 2, 8'hA5, 4'h2, 4'hF};
    vecs[13] = '{8'hA5, 4'h0, 4'h0, 7, 8'hA5, 4'h0, FALL_IRQ ? 4'hD : 4'hF};
    vecs[14] = '{8'hA5, 4'h0, 4'hF, 1, 8'hA5, 4'h0, 4'hF};

    // Reset with all buttons held.
    reset   = 1'b1;
    sw_in   = 8'h00;
    pb_in   = 4'hF;
    irq_ack = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst%0d sw_out", i), sw_out, 8'h00);
      check($sformatf("rst%0d pb_level", i), pb_level, 4'h0);
      check($sformatf("rst%0d irq_n", i), irq_n, 4'hF);
      check($sformatf("rst%0d edges", i), {pb_rise, pb_fall}, 8'h00);
      check($sformatf("rst%0d reset_req", i), reset_req, 1'b0);
    end
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("post_rst edge%0d pb_level", i), pb_level, 4'h0);
    end
    tick();
    check("post_rst edge6 pb_level", pb_level, 4'hF);
    check("post_rst edge6 pb_rise", pb_rise, 4'hF);
    check("post_rst edge6 pb_fall", pb_fall, 4'h0);
    check("post_rst edge6 reset_req", reset_req, 1'b1);
    tick();
    check("post_rst edge7 pb_rise", pb_rise, 4'h0);
    check("post_rst edge7 irq_n", irq_n, 4'h0);
    irq_ack = 4'hF;
    tick();
    irq_ack = 4'h0;
    check("ack_all irq_n", irq_n, 4'hF);

    // Release all buttons: fall pulse timing and fall-irq behaviour.
    pb_in = 4'h0;
    repeat (5) tick();
    check("release edge5 pb_level", pb_level, 4'hF);
    tick();
    check("release edge6 pb_level", pb_level, 4'h0);
    check("release edge6 pb_fall", pb_fall, 4'hF);
    check("release edge6 pb_rise", pb_rise, 4'h0);
    tick();
    check("release edge7 pb_fall", pb_fall, 4'h0);
    check("release edge7 irq_n", irq_n, FALL_IRQ ? 4'h0 : 4'hF);
    irq_ack = 4'hF;
    tick();
    irq_ack = 4'h0;
    check("release ack irq_n", irq_n, 4'hF);

    // Table-driven vectors.
    for (int i = 0; i < 15; i++) begin
      sw_in   = vecs[i].sw;
      pb_in   = vecs[i].pb;
      irq_ack = vecs[i].ack;
      repeat (vecs[i].cycles) tick();
      check($sformatf("vec%0d sw_out", i), sw_out, vecs[i].exp_sw);
      check($sformatf("vec%0d pb_level", i), pb_level, vecs[i].exp_pb);
      check($sformatf("vec%0d irq_n", i), irq_n, vecs[i].exp_irq_n);
    end
    irq_ack = 4'h0;

    // Ack colliding with the pb_rise[2] pulse: set must win.
    pb_in = 4'h4;
    repeat (5) tick();
    check("coll edge5 pb_rise", pb_rise, 4'h0);
    tick();
    check("coll edge6 pb_rise", pb_rise, 4'h4);
    irq_ack = 4'h4;
    tick();
    irq_ack = 4'h0;
    check("coll set_wins irq_n", irq_n, 4'hB);
    tick();
    check("coll hold irq_n", irq_n, 4'hB);
    check("coll pb_rise gone", pb_rise, 4'h0);
    irq_ack = 4'h4;
    tick();
    irq_ack = 4'h0;
    check("coll ack irq_n", irq_n, 4'hF);
    pb_in = 4'h0;
    repeat (7) tick();
    check("coll release pb_level", pb_level, 4'h0);
    irq_ack = 4'hF;
    tick();
    irq_ack = 4'h0;
    check("coll release ack irq_n", irq_n, 4'hF);

    // Reset while pb[0] is two counts into its debounce window.
    pb_in = 4'h1;
    repeat (4) tick();
    check("midrst pre pb_level", pb_level, 4'h0);
    reset = 1'b1;
    tick();
    check("midrst pb_level", pb_level, 4'h0);
    check("midrst sw_out", sw_out, 8'h00);
    check("midrst irq_n", irq_n, 4'hF);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("midrst edge%0d reset_req", i), reset_req, 1'b0);
    end
    tick();
    check("midrst edge6 reset_req", reset_req, 1'b1);
    check("midrst edge6 pb_rise", pb_rise, 4'h1);
    check("midrst edge6 sw_out", sw_out, 8'hA5);
    tick();
    check("midrst irq_n", irq_n, 4'hE);
    irq_ack = 4'h1;
    tick();
    irq_ack = 4'h0;
    check("midrst ack irq_n", irq_n, 4'hF);

    // Press, ack, release pb[3]: fall irq only when the option is built in.
    pb_in = 4'h9;
    repeat (6) tick();
    check("pb3 press pb_level", pb_level, 4'h9);
    check("pb3 press pb_rise", pb_rise, 4'h8);
    tick();
    check("pb3 press irq_n", irq_n, 4'h7);
    irq_ack = 4'h8;
    tick();
    irq_ack = 4'h0;
    check("pb3 ack irq_n", irq_n, 4'hF);
    pb_in = 4'h1;
    repeat (6) tick();
    check("pb3 release pb_fall", pb_fall, 4'h8);
    check("pb3 release pb_level", pb_level, 4'h1);
    tick();
    check("pb3 release irq_n", irq_n, FALL_IRQ ? 4'h7 : 4'hF);
    check("pb3 reset_req held", reset_req, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
